// File: rtl/ram_arb_pkg.sv
// Shared defaults, command encoding and sizing helper for the RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_NUM_REQ    = 2;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    // Bits needed to index `value` entries; never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res++;
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant generator: searches from rr_ptr upward and advances the
// pointer past the winner whenever a grant is taken.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned PTR_W  = clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   rr_ptr
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign rr_ptr = ptr_q;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sharing of one single-port synchronous RAM between NUM_REQ requesters.
// Define RAM_ARB_WR_ACK_EN to make accepted writes return a response too.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout
);

    localparam int unsigned PTR_W = clog2(NUM_REQ);

`ifdef RAM_ARB_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   rr_ptr;
    logic               accept;
    logic [NUM_REQ-1:0] rsp_pend_q, rsp_pend_d;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .accept(accept),
        .gnt   (gnt),
        .rr_ptr(rr_ptr)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);

    // Grant is one-hot, so the first match is the only match.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                ram_we   = req_we[i];
                ram_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                ram_din  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rsp_pend_d = '0;
        if (accept && (ram_we == CMD_RD || (WR_ACK && ram_we == CMD_WR))) begin
            rsp_pend_d = gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pend_q <= '0;
        end else begin
            rsp_pend_q <= rsp_pend_d;
        end
    end

    // Masking by rst drops the response of a read accepted just before reset.
    assign rsp_valid = rsp_pend_q & {NUM_REQ{~rst}};
    assign rsp_rdata = ram_dout;

    ptr_in_range: assert property (@(posedge clk) disable iff (rst) 32'(rr_ptr) < NUM_REQ);
    ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares one single-port synchronous RAM between `NUM_REQ` requesters. Each requester issues read or write commands over a valid/ready handshake. The block grants one requester per cycle, drives the RAM's `we`/`addr`/`din` directly, and routes the RAM's one-cycle-latency read data back to the issuing requester. It sits between client engines and the team's `sync_ram` instance and adds no extra latency on the command path.

## Interface
- `DATA_WIDTH`, 8, RAM word width.
- `ADDR_WIDTH`, 4, RAM address width (depth `1<<ADDR_WIDTH`).
- `NUM_REQ`, 2, number of requesters (2..8).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester command valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_we`  in  NUM_REQ  per-requester command type: 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- `rsp_valid`  out  NUM_REQ  per-requester response strobe, one cycle wide.
- `rsp_rdata`  out  DATA_WIDTH  response data, shared by all requesters; qualified by `rsp_valid`.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_din`  out  DATA_WIDTH  RAM write data.
- `ram_dout`  in  DATA_WIDTH  RAM registered read data.

## Operation
- The grant is combinational from `req_valid` and the round-robin pointer `rr_ptr` (range 0..NUM_REQ-1). The winner is the first asserted `req_valid` at index `rr_ptr`, `rr_ptr+1`, … modulo NUM_REQ.
- `req_ready` is the one-hot grant vector. A command is accepted when `req_valid[i] & req_ready[i]`. The RAM accepts one access per cycle, so a granted requester is never stalled.
- RAM mux: `ram_addr`/`ram_din` come from the granted requester. `ram_we` = granted `req_we`. With no grant: `ram_we`=0, `ram_addr`=0, `ram_din`=0.
- Pointer update: on acceptance by requester g, `rr_ptr` ← (g+1) mod NUM_REQ. With no acceptance, `rr_ptr` holds.
- Response tracking: registered `rsp_pend` (one-hot, NUM_REQ bits) is set to the accepted requester's bit for a read, and cleared otherwise.
  - `rsp_valid` = `rsp_pend`.
  - `rsp_rdata` = `ram_dout` (pass-through; the RAM output is already registered).
- Hazards: the RAM returns old data when a read and a write hit the same address in the same cycle. This cannot happen here, because there is one access per cycle. A write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- Requesters must hold `req_addr`/`req_we`/`req_wdata` stable while `req_valid` is high and not yet accepted.
- Reset (any cycle, including mid-transaction):
  - `rr_ptr` ← 0 and `rsp_pend` ← 0.
  - While `rst` is high: `req_ready`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0.
  - A read accepted in the cycle before `rst` rises produces no response.
- Outputs immediately after reset: `rsp_valid`=0. `rsp_rdata` follows `ram_dout` (the RAM has no reset, so this value is undefined).

## Timing
- Command path is combinational: `req_valid` → `req_ready`/`ram_*` in the same cycle.
- Read latency:
  - Read accepted at edge N.
  - `rsp_valid[i]`=1 and `rsp_rdata` valid during cycle N+1, for exactly one cycle.
- Back-to-back reads from alternating requesters: one response per cycle, in acceptance order.
- Fairness: a continuously-valid requester waits at most NUM_REQ-1 cycles for a grant.

## Configuration
- `RAM_ARB_WR_ACK_EN` defined:
  - Accepted writes also set `rsp_pend`, so `rsp_valid[i]` pulses at N+1.
  - `rsp_rdata` then carries the pre-write contents of the address (RAM read-before-write).
- Not defined: writes produce no response. `rsp_valid` is raised only for reads.

## Structure
- Shared package `ram_arb_pkg` holds:
  - default `DATA_WIDTH`/`ADDR_WIDTH`/`NUM_REQ`;
  - the `clog2` function used to size `rr_ptr`;
  - the command-type constants `CMD_RD`=0 and `CMD_WR`=1.
- Sub-module `rr_arbiter` (parameter NUM_REQ) contains:
  - inputs `clk`, `rst`, `req`, `accept`;
  - outputs `gnt` (one-hot) and the `rr_ptr` register.
- The top level contains the RAM mux, `rsp_pend` and response routing.

## Test plan
- Reset, idle and single write/read:
  - Hold `rst`=1 for 3 cycles; then req0 writes 0xA5 to address 3; next cycle req0 reads address 3.
  - Expected: during reset all `req_ready`/`ram_we` = 0; `ram_we`=1 with `ram_addr`=3 in the write cycle; `rsp_valid`=01 and `rsp_rdata`=0xA5 one cycle after the read.
- Contention:
  - Both requesters continuously valid with reads of addresses 1 and 2, `rr_ptr`=0.
  - Expected: grants 01, 10, 01, 10…; responses alternate with data mem[1] and mem[2], each one cycle after its grant.
- Write/read across requesters:
  - req1 writes 0x3C to address 7 at cycle N; req0 reads address 7 at N+1.
  - Expected: req0 receives 0x3C.
- Reset mid-read:
  - req1 read accepted at N; `rst`=1 at N+1.
  - Expected: `rsp_valid`=0 at N+1; `rr_ptr`=0 afterwards.
- Write ack (`RAM_ARB_WR_ACK_EN`):
  - Address 5 holds 0x11; req1 writes 0x22 to it.
  - Expected with the macro: `rsp_valid`=10 and `rsp_rdata`=0x11 the next cycle. Expected without the macro: `rsp_valid`=00.
- Fairness sweep with NUM_REQ=4 and all requesters valid for 16 cycles.
  - Expected: each requester granted exactly 4 times; no gap longer than 3 cycles.
